instruction_memory: RTL and testbench

- Word-organised instruction store for the single-cycle RISC-V datapath; sits between the PC register and the decoder.
- Byte address in, 32-bit instruction out, read is combinational within the same cycle.
- Holds a fixed default program image, restored on reset.
- Optional synchronous write port loads new programs.

---
 rtl/imem_pkg.sv | 44 ++++
 rtl/imem_default_rom.sv | 19 +
 rtl/instruction_memory.sv | 106 ++++++++++
 tb/tb_instruction_memory.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared constants and helpers for the instruction memory.
//   NOP_INSTR      : word returned for any fetch outside the store (addi x0,x0,0)
//   DEFAULT_IMAGE  : the built-in program, word 0 first
//   word_index()   : byte address -> word index (drops the two byte-offset bits)
//   default_word() : word index -> default image word (NOP past the program)
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int unsigned IMEM_ADDR_W = 64;
   localparam int unsigned IMEM_IDX_W  = IMEM_ADDR_W - 2;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int unsigned DEFAULT_LEN = 9;
   localparam logic [31:0] DEFAULT_IMAGE [DEFAULT_LEN] = '{
      32'h0050_0093,   // byte 0
      32'h00A0_0113,   // byte 4
      32'h0020_81B3,   // byte 8
      32'h4020_8233,   // byte 12
      32'h0020_F2B3,   // byte 16
      32'h0020_E333,   // byte 20
      32'h0030_3023,   // byte 24
      32'h0000_3383,   // byte 28
      32'h0071_8463    // byte 32
   };

   function automatic logic [IMEM_IDX_W-1:0] word_index(input logic [IMEM_ADDR_W-1:0] address);
      return address[IMEM_ADDR_W-1:2];
   endfunction

   function automatic logic [31:0] default_word(input logic [IMEM_IDX_W-1:0] index);
      logic [31:0] word;
      logic [3:0]  slot;
      slot = index[3:0];
      word = NOP_INSTR;
      if (index < IMEM_IDX_W'(DEFAULT_LEN)) begin
         word = DEFAULT_IMAGE[slot];
      end
      return word;
   endfunction

endpackage

// File: rtl/imem_default_rom.sv
// -----------------------------------------------------------------------------
// imem_default_rom
// Combinational lookup of the default program word for a given word index.
// Ports:
//   index : word index into the store (IDX_W bits)
//   word  : default image word at that index (NOP beyond the built-in program)
// -----------------------------------------------------------------------------
module imem_default_rom
   import imem_pkg::*;
#(
   parameter int unsigned IDX_W = 6
) (
   input  logic [IDX_W-1:0] index,
   output logic [31:0]      word
);

   assign word = default_word(IMEM_IDX_W'(index));

endmodule

// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
// Word-organised instruction store for the single-cycle datapath. Byte address
// in, 32-bit instruction out, zero-latency combinational read.
//
// Build option: define IMEM_WRITE_EN to add the synchronous write port
// (we/waddr/wdata). Without it the contents are the fixed default image and
// clk/reset have no observable effect.
//
// Ports:
//   clk        : rising-edge clock for reset reload and writes
//   reset      : synchronous, active-high; restores the default image
//   address    : byte address to fetch
//   I          : instruction at word address[ADDR_W-1:2], NOP when out of range
//   misaligned : address[1:0] != 0 (the aligned word is still returned)
//   addr_err   : word index >= DEPTH (no wrap-around)
//   we/waddr/wdata (IMEM_WRITE_EN only) : write word wdata at waddr>>2
// -----------------------------------------------------------------------------
module instruction_memory
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] I,
   output logic              misaligned,
   output logic              addr_err
`ifdef IMEM_WRITE_EN
   ,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
`endif
);

   localparam int unsigned           IDX_W   = $clog2(DEPTH);
   localparam logic [IMEM_IDX_W-1:0] DEPTH_W = IMEM_IDX_W'(DEPTH);

   // ---------------------------------------------------------------- read path
   logic [IMEM_IDX_W-1:0] rd_word;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_in_range;
   logic [DATA_W-1:0]     rom_rd_word;
   logic [DATA_W-1:0]     rd_data;

   // Range check uses the full word index, so any high address bit flags an
   // error instead of aliasing onto a low word.
   assign rd_word     = word_index(IMEM_ADDR_W'(address));
   assign rd_idx      = rd_word[IDX_W-1:0];
   assign rd_in_range = (rd_word < DEPTH_W);

   imem_default_rom #(.IDX_W(IDX_W)) u_rom_rd (
      .index (rd_idx),
      .word  (rom_rd_word)
   );

   assign misaligned = |address[1:0];
   assign addr_err   = ~rd_in_range;
   assign I          = rd_in_range ? rd_data : NOP_INSTR;

`ifdef IMEM_WRITE_EN
   // --------------------------------------------------------------- write path
   // The store holds each word as the XOR difference from the default image.
   // An all-zero array therefore *is* the default program: registers come up
   // zero at configuration, and reset only has to clear the array to reload
   // every word at once. Reads recombine with the ROM word combinationally.
   logic [DATA_W-1:0]     delta_reg [DEPTH];
   logic [IMEM_IDX_W-1:0] wr_word;
   logic [IDX_W-1:0]      wr_idx;
   logic                  wr_in_range;
   logic [DATA_W-1:0]     rom_wr_word;

   assign wr_word     = word_index(IMEM_ADDR_W'(waddr));
   assign wr_idx      = wr_word[IDX_W-1:0];
   assign wr_in_range = (wr_word < DEPTH_W);

   imem_default_rom #(.IDX_W(IDX_W)) u_rom_wr (
      .index (wr_idx),
      .word  (rom_wr_word)
   );

   // Reset has priority over a same-cycle write; out-of-range writes drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            delta_reg[i] <= '0;
         end
      end else if (we && wr_in_range) begin
         delta_reg[wr_idx] <= wdata ^ rom_wr_word;
      end
   end

   // No bypass: a word being written reads its old value until the edge.
   assign rd_data = rom_rd_word ^ delta_reg[rd_idx];
`else
   // Read-only build: contents are the constant default image.
   logic unused_ctrl;
   assign unused_ctrl = clk ^ reset;
   assign rd_data     = rom_rd_word;
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
// Scoreboard bench for instruction_memory: each read pushes its expected
// instruction/flags when the address is driven and pops/compares when the
// output is sampled. Write-port checks are built only with IMEM_WRITE_EN.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      string       tag;
      logic [63:0] addr;
      logic [31:0] instr;
      logic        mis;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [63:0] address;
   logic [31:0] I;
   logic        misaligned;
   logic        addr_err;
`ifdef IMEM_WRITE_EN
   logic        we;
   logic [63:0] waddr;
   logic [31:0] wdata;
`endif

   exp_t sb_q [$];
   int   n_cmp;
   int   n_bad;

   logic [31:0] step_tab [11] = '{
      32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h4020_8233,
      32'h0020_F2B3, 32'h0020_E333, 32'h0030_3023, 32'h0000_3383,
      32'h0071_8463, 32'h0000_0013, 32'h0000_0013
   };

   instruction_memory #(
      .DEPTH  (64),
      .ADDR_W (64),
      .DATA_W (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .I          (I),
      .misaligned (misaligned),
      .addr_err   (addr_err)
`ifdef IMEM_WRITE_EN
      ,
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic sample_read();
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         $display("rd %-12s addr=%h I=%h mis=%b err=%b", e.tag, e.addr, I, misaligned, addr_err);
         check_eq({e.tag, ".I"},   64'(I),          64'(e.instr));
         check_eq({e.tag, ".mis"}, 64'(misaligned), 64'(e.mis));
         check_eq({e.tag, ".err"}, 64'(addr_err),   64'(e.err));
      end
   endtask

   // Drive an address, record what it must read, then sample 2 ns later
   // without any clock edge in between.
   task automatic drive_read(input string tag, input logic [63:0] a,
                             input logic [31:0] ei, input logic em, input logic ee);
      exp_t e;
      e.tag   = tag;
      e.addr  = a;
      e.instr = ei;
      e.mis   = em;
      e.err   = ee;
      address = a;
      sb_q.push_back(e);
      #2;
      sample_read();
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      reset   = 1'b1;
      address = '0;
`ifdef IMEM_WRITE_EN
      we      = 1'b0;
      waddr   = '0;
      wdata   = '0;
`endif
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);

      // Sequential fetch through the default program and past its end.
      for (int i = 0; i < 11; i++) begin
         drive_read("step", 64'(i * 4), step_tab[i], 1'b0, 1'b0);
         #3;
      end

      drive_read("mis9",     64'd9,   32'h0020_81B3, 1'b1, 1'b0);
      drive_read("mis254",   64'd254, NOP,           1'b1, 1'b0);
      drive_read("last_ok",  64'd252, NOP,           1'b0, 1'b0);
      drive_read("oob256",   64'd256, NOP,           1'b0, 1'b1);
      drive_read("oob_msb",  64'h8000_0000_0000_0000, NOP, 1'b0, 1'b1);
      drive_read("alias0",   64'h8000_0000_0000_0004, NOP, 1'b0, 1'b1);
      drive_read("back12",   64'd12,  32'h4020_8233, 1'b0, 1'b0);

`ifdef IMEM_WRITE_EN
      // Write word 1: old value before the edge, new value after it.
      @(negedge clk);
      we    = 1'b1;
      waddr = 64'd4;
      wdata = 32'hDEAD_BEEF;
      drive_read("wr_old", 64'd4, 32'h00A0_0113, 1'b0, 1'b0);
      @(posedge clk);
      #1 we = 1'b0;
      drive_read("wr_new", 64'd4, 32'hDEAD_BEEF, 1'b0, 1'b0);

      // Out-of-range write is dropped and must not wrap onto word 36.
      @(negedge clk);
      we    = 1'b1;
      waddr = 64'd400;
      wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 we = 1'b0;
      drive_read("oob_keep4", 64'd4,   32'hDEAD_BEEF, 1'b0, 1'b0);
      drive_read("oob_400",   64'd400, NOP,           1'b0, 1'b1);
      drive_read("oob_wrap",  64'd144, NOP,           1'b0, 1'b0);

      // Misaligned write address lands on the aligned last word.
      @(negedge clk);
      we    = 1'b1;
      waddr = 64'd254;
      wdata = 32'h0BAD_C0DE;
      @(posedge clk);
      #1 we = 1'b0;
      drive_read("wr_last", 64'd252, 32'h0BAD_C0DE, 1'b0, 1'b0);

      // Reset and write together: reset wins, image restored everywhere.
      @(negedge clk);
      reset = 1'b1;
      we    = 1'b1;
      waddr = 64'd4;
      wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      reset = 1'b0;
      we    = 1'b0;
      drive_read("rst_wins",  64'd4,   32'h00A0_0113, 1'b0, 1'b0);
      drive_read("rst_last",  64'd252, NOP,           1'b0, 1'b0);
`else
      // Read-only build: reset leaves the image unchanged.
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      drive_read("rst_noeff", 64'd4, 32'h00A0_0113, 1'b0, 1'b0);
`endif

      if (sb_q.size() != 0) begin
         check_eq("scoreboard_left", 64'(sb_q.size()), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
